posit_pack: RTL and testbench

Final packing stage of the float-to-posit conversion path. It sits directly downstream of `round_off` and consumes its MSB-aligned fraction word together with the regime value `k`, the 3-bit exponent, the sign and the special-case flags. It assembles a 32-bit posit (es = 3), rounds it to nearest-even, and saturates and negates the result. It is a two-stage valid/ready pipeline, so it can run back-to-back or stall under downstream backpressure.

---
 rtl/posit_pack.sv | 121 ++++++++++++
 tb/tb_posit_pack.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_pack.sv
// posit_pack: assembles regime/exponent/fraction into a 32-bit posit (es=3) with round-to-nearest-even, saturation and sign.
// Latency: 2 cycles; the accepting edge fills stage 1 and the following edge registers out_posit/out_valid.
// Backpressure: two-stage valid/ready pipe. in_ready is combinational from out_ready and falls only when both stages are full.
module posit_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_k,
  input  logic [2:0]  in_exp,
  input  logic [31:0] in_frac,
  input  logic        in_sticky,
  input  logic        in_zero,
  input  logic        in_nar,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_posit
);

  // Pipeline control.
  logic s1_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1 combinational assembly.
  logic        k_hi;
  logic        k_lo;
  logic [5:0]  kc;      // clamped k, 6-bit two's complement in [-30, 30]
  logic [4:0]  sh;      // regime length minus one
  logic [67:0] base;
  logic [67:0] ones;
  logic [67:0] wv;
  logic [30:0] a_body;
  logic        a_guard;
  logic        a_sticky;

  // Clamp k, then shift {terminator, exp, frac} right behind the regime run.
  // The working vector carries 32 pad bits so even the longest regime keeps
  // every fraction bit inside the sticky window.
  always_comb begin
    k_hi     = $signed(in_k) > 8'sd30;
    k_lo     = $signed(in_k) < -8'sd30;
    kc       = k_hi ? 6'd30 : (k_lo ? 6'b100010 : in_k[5:0]);
    sh       = kc[5] ? (5'd0 - kc[4:0]) : (kc[4:0] + 5'd1);
    base     = {kc[5], in_exp, in_frac, 32'd0};
    ones     = kc[5] ? 68'd0 : ~({68{1'b1}} >> sh);
    wv       = (base >> sh) | ones;
    a_body   = wv[67:37];
    a_guard  = wv[36];
    a_sticky = (|wv[35:0]) | in_sticky;
  end

  // Stage 1 occupancy; cleared asynchronously so in-flight beats are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      s1_valid <= 1'b0;
    else if (s1_adv)
      s1_valid <= in_valid;
  end

  logic [30:0] s1_body;
  logic        s1_guard;
  logic        s1_sticky;
  logic        s1_sign;
  logic        s1_zero;
  logic        s1_nar;
  logic        s1_sat;

  // Stage 1 payload; only the valid bit needs a reset.
  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) begin
      s1_body   <= a_body;
      s1_guard  <= a_guard;
      s1_sticky <= a_sticky;
      s1_sign   <= in_sign;
      s1_zero   <= in_zero;
      s1_nar    <= in_nar;
      s1_sat    <= k_hi;
    end
  end

  // Stage 2 combinational round, saturate, negate and special-case override.
  logic        rnd;
  logic [31:0] sum;
  logic [30:0] mag;
  logic [31:0] res;

  always_comb begin
    rnd = s1_guard && (s1_body[0] || s1_sticky);
    sum = {1'b0, s1_body} + {31'd0, rnd};
    if (sum[31] || s1_sat)
      mag = 31'h7FFF_FFFF;
    else if (sum[30:0] == 31'd0)
      mag = 31'd1;
    else
      mag = sum[30:0];
    res = s1_sign ? (32'd0 - {1'b0, mag}) : {1'b0, mag};
    if (s1_nar)
      res = 32'h8000_0000;
    else if (s1_zero)
      res = 32'h0000_0000;
  end

  // Output register; holds its value while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_posit <= 32'd0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid)
        out_posit <= res;
    end
  end

endmodule

// File: tb/tb_posit_pack.sv
// tb_posit_pack: directed and randomized checks of posit_pack against a bit-list reference model.
// Latency: inputs driven 1ns after a rising edge, outputs sampled on the falling edge.
// Backpressure: random out_ready stalls, hold-stability and in-order scoreboard checks.
module tb_posit_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_k;
  logic [2:0]  in_exp;
  logic [31:0] in_frac;
  logic        in_sticky;
  logic        in_zero;
  logic        in_nar;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_posit;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] expq[$];
  bit          held = 1'b0;
  logic [31:0] held_val;
  bit          acc_last = 1'b0;

  posit_pack dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_k(in_k), .in_exp(in_exp), .in_frac(in_frac),
    .in_sticky(in_sticky), .in_zero(in_zero), .in_nar(in_nar),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: build the posit bit string as a list, cut it at 31 bits, round as integers.
  function automatic logic [31:0] ref_posit(bit s, int k, bit [2:0] e, bit [31:0] f,
                                            bit st, bit z, bit n);
    bit     bits[$];
    int     kc;
    longint body;
    bit     guard;
    bit     sticky;
    longint r;
    if (n) return 32'h8000_0000;
    if (z) return 32'h0000_0000;
    kc = (k > 30) ? 30 : ((k < -30) ? -30 : k);
    if (kc >= 0) begin
      for (int i = 0; i < kc + 1; i++) bits.push_back(1'b1);
      bits.push_back(1'b0);
    end else begin
      for (int i = 0; i < -kc; i++) bits.push_back(1'b0);
      bits.push_back(1'b1);
    end
    for (int i = 2; i >= 0; i--) bits.push_back(e[i]);
    for (int i = 31; i >= 0; i--) bits.push_back(f[i]);
    body = 0;
    for (int i = 0; i < 31; i++) body = body * 2 + longint'(bits[i]);
    guard  = bits[31];
    sticky = st;
    for (int i = 32; i < bits.size(); i++) sticky = sticky | bits[i];
    if (guard && ((body % 2) == 1 || sticky)) body = body + 1;
    if (body >= 64'h8000_0000 || k > 30) body = 64'h7FFF_FFFF;
    if (body == 0) body = 1;
    r = s ? -body : body;
    return r[31:0];
  endfunction

  task automatic set_beat(input bit s, input logic [7:0] k, input logic [2:0] e,
                          input logic [31:0] f, input bit st, input bit z, input bit n);
    in_sign = s; in_k = k; in_exp = e; in_frac = f;
    in_sticky = st; in_zero = z; in_nar = n;
  endtask

  task automatic rand_beat();
    logic [7:0] k;
    logic [31:0] f;
    bit st;
    k  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 24) - 12);
    f  = $urandom;
    st = 1'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      f[15:0] = 16'd0;
      st = 1'b0;
    end
    set_beat(1'($urandom), k, 3'($urandom), f, st,
             $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
  endtask

  // Directed single beat through an empty pipe: result expected after the second edge.
  task automatic run_vec(input string tag, input bit s, input logic [7:0] k, input logic [2:0] e,
                         input logic [31:0] f, input bit st, input bit z, input bit n,
                         input logic [31:0] want);
    @(posedge clk); #1;
    set_beat(s, k, e, f, st, z, n);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early_valid"}, out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out_posit, want);
  endtask

  // Falling-edge bookkeeping for the randomized phase.
  task automatic sample();
    acc_last = in_valid && in_ready;
    if (acc_last)
      expq.push_back(ref_posit(in_sign, int'($signed(in_k)), in_exp, in_frac,
                               in_sticky, in_zero, in_nar));
    if (held) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_posit, held_val);
    end
    held = 1'b0;
    if (out_valid) begin
      if (out_ready) begin
        if (expq.size() == 0) check("spurious_out", out_valid, 0);
        else check("rand_data", out_posit, expq.pop_front());
      end else begin
        held = 1'b1;
        held_val = out_posit;
      end
    end
  endtask

  initial begin
    int acc;
    logic [7:0] bp_k[4];
    int bp_i;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_beat(0, 8'd0, 3'd0, 32'd0, 0, 0, 0);
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_posit", out_posit, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Directed values.
    run_vec("unit",       0, 8'd0,   3'd0, 32'h0,        0, 0, 0, 32'h4000_0000);
    run_vec("unit_neg",   1, 8'd0,   3'd0, 32'h0,        0, 0, 0, 32'hC000_0000);
    run_vec("k_m1",       0, 8'hFF,  3'd0, 32'h0,        0, 0, 0, 32'h2000_0000);
    run_vec("k_30",       0, 8'd30,  3'd0, 32'h0,        0, 0, 0, 32'h7FFF_FFFF);
    run_vec("k_40",       0, 8'd40,  3'd0, 32'h0,        0, 0, 0, 32'h7FFF_FFFF);
    run_vec("k_m30",      0, 8'hE2,  3'd0, 32'h0,        0, 0, 0, 32'h0000_0001);
    run_vec("k_m50",      0, 8'hCE,  3'd0, 32'h0,        0, 0, 0, 32'h0000_0001);
    run_vec("k_m128",     0, 8'h80,  3'd7, 32'hFFFF_FFFF, 1, 0, 0, 32'h0000_0002);
    run_vec("rnd_tie",    0, 8'd0,   3'd0, 32'h20,       0, 0, 0, 32'h4000_0000);
    run_vec("rnd_up",     0, 8'd0,   3'd0, 32'h60,       0, 0, 0, 32'h4000_0002);
    run_vec("rnd_sticky", 0, 8'd0,   3'd0, 32'h20,       1, 0, 0, 32'h4000_0001);
    run_vec("rnd_carry",  0, 8'd0,   3'd0, 32'hFFFF_FFE0, 0, 0, 0, 32'h4400_0000);
    run_vec("zero",       0, 8'd5,   3'd3, 32'h1234,     0, 1, 0, 32'h0000_0000);
    run_vec("nar_zero",   1, 8'd5,   3'd3, 32'h1234,     0, 1, 1, 32'h8000_0000);
    run_vec("neg_max",    1, 8'd30,  3'd0, 32'h0,        0, 0, 0, 32'h8000_0001);

    // Backpressure: four beats offered with the consumer stalled.
    bp_k[0] = 8'd0; bp_k[1] = 8'hFF; bp_k[2] = 8'd1; bp_k[3] = 8'd2;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    bp_i = 0;
    set_beat(0, bp_k[0], 3'd0, 32'h0, 0, 0, 0);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready_%0d", i), in_ready, (i < 2) ? 1 : 0);
      if (in_valid && in_ready) begin
        acc++;
        bp_i++;
      end
      @(posedge clk); #1;
      set_beat(0, bp_k[bp_i], 3'd0, 32'h0, 0, 0, 0);
    end
    check("bp_accepted", 32'(acc), 2);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_first_valid", out_valid, 1);
    check("bp_first_held", out_posit, 32'h4000_0000);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_first_data", out_posit, 32'h4000_0000);
    @(posedge clk);
    @(negedge clk);
    check("bp_second_valid", out_valid, 1);
    check("bp_second_data", out_posit, 32'h2000_0000);
    @(posedge clk);
    @(negedge clk);
    check("bp_drained", out_valid, 0);

    // Reset in the middle of a stall with two beats buffered.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_beat(0, 8'd0, 3'd0, 32'h0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rs_full_valid", out_valid, 1);
    check("rs_full_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("rs_out_valid", out_valid, 0);
    check("rs_out_posit", out_posit, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rs_in_ready", in_ready, 1);
    check("rs_discarded", out_valid, 0);
    run_vec("rs_next", 1, 8'd0, 3'd0, 32'h0, 0, 0, 0, 32'hC000_0000);

    // Randomized traffic with random backpressure against the reference model.
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    held = 1'b0;
    acc_last = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk); #1;
      if (!in_valid || acc_last) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_beat();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      sample();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sample();
      @(posedge clk); #1;
    end
    check("drain_empty", 32'(expq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
